// File: rtl/controle_ajuste_if.sv
// Button inputs and enable/status outputs of the clock mode controller.
// The controller uses the slave modport; the driver of the buttons uses master.
interface controle_ajuste_if;
    logic       btn_mode;
    logic       btn_inc;
    logic       sec_en;
    logic       sec_clr;
    logic       min_en;
    logic       hour_en;
    logic [1:0] mode;
    logic       blink_min;
    logic       blink_hour;

    modport master (
        output btn_mode, btn_inc,
        input  sec_en, sec_clr, min_en, hour_en, mode, blink_min, blink_hour
    );

    modport slave (
        input  btn_mode, btn_inc,
        output sec_en, sec_clr, min_en, hour_en, mode, blink_min, blink_hour
    );
endinterface

// File: rtl/controle_ajuste.sv
// Mode/sequence controller for the seconds/minutes/hours counter chain: 1 Hz enable,
// RUN -> SET_MIN -> SET_HOUR setting FSM, debounced buttons, auto-repeat and blink flags.
module controle_ajuste #(
    parameter int unsigned PRESC_DIV  = 50000000,
    parameter int unsigned DEB_CYCLES = 1000000,
    parameter int unsigned REPEAT_DLY = 50000000,
    parameter int unsigned REPEAT_PER = 10000000,
    parameter int unsigned BLINK_DIV  = 25000000
) (
    input  logic             clk,
    input  logic             reset,
    controle_ajuste_if.slave bus_io
);
    localparam int unsigned PW   = $clog2(PRESC_DIV + 1);
    localparam int unsigned DW   = $clog2(DEB_CYCLES + 1);
    localparam int unsigned RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int unsigned RW   = $clog2(RMAX + 1);
    localparam int unsigned BW   = $clog2(BLINK_DIV + 1);

    localparam logic [1:0] StRun     = 2'b00;
    localparam logic [1:0] StSetMin  = 2'b01;
    localparam logic [1:0] StSetHour = 2'b10;

    // Index 0 is the mode button, index 1 the increment button.
    logic [1:0]         sync1_q, sync2_q;
    logic [1:0]         deb_q, deb_d, deb_prev_q, press_q;
    logic [1:0][DW-1:0] deb_cnt_q, deb_cnt_d;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          rep_act_q, rep_act_d;
    logic          rep_first_q, rep_first_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;
    logic          min_en_q, min_en_d;
    logic          hour_en_q, hour_en_d;
    logic          sec_clr_q, sec_clr_d;

    logic mode_press, inc_press, inc_lvl, in_set, mode_chg, inc_fire, rep_hit;

    assign mode_press = press_q[0];
    assign inc_press  = press_q[1];
    assign inc_lvl    = deb_q[1];
    assign in_set     = (state_q == StSetMin) || (state_q == StSetHour);
    assign mode_chg   = (state_d != state_q);

    // A level is accepted only after DEB_CYCLES consecutive disagreeing samples.
    always_comb begin
        deb_cnt_d = deb_cnt_q;
        deb_d     = deb_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
                deb_cnt_d[i] = '0;
            end else if (deb_cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
                deb_cnt_d[i] = '0;
                deb_d[i]     = sync2_q[i];
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            press_q    <= '0;
            deb_cnt_q  <= '0;
        end else begin
            sync1_q    <= {bus_io.btn_inc, bus_io.btn_mode};
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            press_q    <= deb_q & ~deb_prev_q;
            deb_cnt_q  <= deb_cnt_d;
        end
    end

    assign rep_hit = rep_first_q ? (rep_cnt_q == RW'(REPEAT_DLY - 1))
                                 : (rep_cnt_q == RW'(REPEAT_PER - 1));

    always_comb begin
        state_d     = state_q;
        sec_clr_d   = 1'b0;
        presc_d     = '0;
        rep_cnt_d   = rep_cnt_q;
        rep_act_d   = rep_act_q;
        rep_first_d = rep_first_q;
        inc_fire    = 1'b0;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;

        case (state_q)
            StRun: begin
                if (mode_press) state_d = StSetMin;
            end
            StSetMin: begin
                if (mode_press) state_d = StSetHour;
            end
            StSetHour: begin
                if (mode_press) begin
                    state_d   = StRun;
                    sec_clr_d = 1'b1;
                end
            end
            default: state_d = StRun;
        endcase

        // Prescaler only runs while staying in RUN, so re-entry restarts a full period.
        if (state_q == StRun && !mode_chg) begin
            presc_d = (presc_q == PW'(PRESC_DIV - 1)) ? '0 : presc_q + PW'(1);
        end

        // Mode wins over a coincident inc press and always drops any pending repeat.
        if (mode_chg || !in_set) begin
            rep_act_d = 1'b0;
            rep_cnt_d = '0;
        end else if (inc_press) begin
            inc_fire    = 1'b1;
            rep_act_d   = 1'b1;
            rep_first_d = 1'b1;
            rep_cnt_d   = '0;
        end else if (!inc_lvl) begin
            rep_act_d = 1'b0;
            rep_cnt_d = '0;
        end else if (rep_act_q) begin
            if (rep_hit) begin
                inc_fire    = 1'b1;
                rep_first_d = 1'b0;
                rep_cnt_d   = '0;
            end else begin
                rep_cnt_d = rep_cnt_q + RW'(1);
            end
        end

        if (mode_chg || state_q == StRun) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
        end

        min_en_d  = inc_fire && (state_q == StSetMin);
        hour_en_d = inc_fire && (state_q == StSetHour);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StRun;
            presc_q     <= '0;
            rep_cnt_q   <= '0;
            rep_act_q   <= 1'b0;
            rep_first_q <= 1'b0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            min_en_q    <= 1'b0;
            hour_en_q   <= 1'b0;
            sec_clr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            rep_cnt_q   <= rep_cnt_d;
            rep_act_q   <= rep_act_d;
            rep_first_q <= rep_first_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            min_en_q    <= min_en_d;
            hour_en_q   <= hour_en_d;
            sec_clr_q   <= sec_clr_d;
        end
    end

    assign bus_io.sec_en     = (state_q == StRun) && (presc_q == PW'(PRESC_DIV - 1));
    assign bus_io.sec_clr    = sec_clr_q;
    assign bus_io.min_en     = min_en_q;
    assign bus_io.hour_en    = hour_en_q;
    assign bus_io.mode       = state_q;
    assign bus_io.blink_min  = (state_q == StSetMin) && phase_q;
    assign bus_io.blink_hour = (state_q == StSetHour) && phase_q;

endmodule

// File: tb/tb_controle_ajuste.sv
// Bench for controle_ajuste: directed scenarios plus random button traffic, every cycle
// compared against a window-based behavioural model of debounce, FSM, repeat and blink.
module tb_controle_ajuste;
    localparam int PRESC_DIV  = 10;
    localparam int DEB_CYCLES = 4;
    localparam int REPEAT_DLY = 20;
    localparam int REPEAT_PER = 5;
    localparam int BLINK_DIV  = 3;
    localparam int HMAX       = 8192;

    logic clk;
    logic reset;
    controle_ajuste_if bus ();

    controle_ajuste #(
        .PRESC_DIV (PRESC_DIV),
        .DEB_CYCLES(DEB_CYCLES),
        .REPEAT_DLY(REPEAT_DLY),
        .REPEAT_PER(REPEAT_PER),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus_io(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model state: t counts clock edges since reset release (first edge is 1).
    int   t;
    logic raw_h [2][HMAX];
    logic deb_h [2][HMAX];
    logic [1:0] m_deb;
    int   m_mode, run_start, mode_start, first_pulse;
    bit   rep_armed;
    int   e_sec, e_clr, e_min, e_hour, e_bmin, e_bhour;

    int n_sec, n_clr, n_min, n_hour, t_min, t_rise;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s at edge %0d: observed=%0d expected=%0d", tag, t, obs, exp);
        end
    endtask

    function automatic void model_reset();
        t          = 0;
        m_deb      = '0;
        m_mode     = 0;
        run_start  = 0;
        mode_start = 0;
        rep_armed  = 0;
        e_sec = 0; e_clr = 0; e_min = 0; e_hour = 0; e_bmin = 0; e_bhour = 0;
    endfunction

    function automatic void model_step();
        logic [1:0] lvl_before;
        logic [1:0] pe;
        bit         all_diff;
        bit         fire;
        logic       r, older;
        t++;
        raw_h[0][t] = bus.btn_mode;
        raw_h[1][t] = bus.btn_inc;
        lvl_before  = m_deb;
        for (int i = 0; i < 2; i++) begin
            // Two sync stages: the sample seen by the debouncer at edge t was taken at t-2.
            all_diff = 1;
            for (int k = 2; k <= DEB_CYCLES + 1; k++) begin
                r = (t - k >= 1) ? raw_h[i][t-k] : 1'b0;
                if (r == m_deb[i]) all_diff = 0;
            end
            if (all_diff) m_deb[i] = ~m_deb[i];
            deb_h[i][t] = m_deb[i];
            older = (t - 3 >= 1) ? deb_h[i][t-3] : 1'b0;
            pe[i] = (t - 2 >= 1) && deb_h[i][t-2] && !older;
        end

        e_clr = 0; e_min = 0; e_hour = 0;
        if (pe[0]) begin
            if (m_mode == 2) e_clr = 1;
            m_mode     = (m_mode + 1) % 3;
            mode_start = t;
            rep_armed  = 0;
            if (m_mode == 0) run_start = t;
        end else if (m_mode != 0) begin
            fire = 0;
            if (pe[1]) begin
                fire        = 1;
                rep_armed   = 1;
                first_pulse = t;
            end else if (!lvl_before[1]) begin
                rep_armed = 0;
            end else if (rep_armed && (t - first_pulse) >= REPEAT_DLY &&
                         ((t - first_pulse - REPEAT_DLY) % REPEAT_PER) == 0) begin
                fire = 1;
            end
            if (fire) begin
                if (m_mode == 1) e_min = 1;
                else e_hour = 1;
            end
        end
        e_sec   = (m_mode == 0) && ((t - run_start) % PRESC_DIV == PRESC_DIV - 1);
        e_bmin  = (m_mode == 1) && (((t - mode_start) / BLINK_DIV) % 2 == 1);
        e_bhour = (m_mode == 2) && (((t - mode_start) / BLINK_DIV) % 2 == 1);
    endfunction

    task automatic check_all();
        chk("sec_en", 32'(bus.sec_en), 32'(e_sec));
        chk("sec_clr", 32'(bus.sec_clr), 32'(e_clr));
        chk("min_en", 32'(bus.min_en), 32'(e_min));
        chk("hour_en", 32'(bus.hour_en), 32'(e_hour));
        chk("mode", 32'(bus.mode), 32'(m_mode));
        chk("blink_min", 32'(bus.blink_min), 32'(e_bmin));
        chk("blink_hour", 32'(bus.blink_hour), 32'(e_bhour));
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_step();
        #1;
        check_all();
        n_sec  += int'(bus.sec_en);
        n_clr  += int'(bus.sec_clr);
        n_min  += int'(bus.min_en);
        n_hour += int'(bus.hour_en);
        if (bus.min_en === 1'b1) t_min = t;
    endtask

    task automatic press_mode();
        bus.btn_mode = 1'b1;
        repeat (6) tick();
        bus.btn_mode = 1'b0;
        repeat (8) tick();
    endtask

    task automatic hold_inc(input int n);
        bus.btn_inc = 1'b1;
        repeat (n) tick();
        bus.btn_inc = 1'b0;
    endtask

    initial begin
        reset        = 1'b0;
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        model_reset();
        n_sec = 0; n_clr = 0; n_min = 0; n_hour = 0; t_min = -1; t_rise = 0;
        repeat (3) @(posedge clk);
        #1;
        check_all();
        reset = 1'b1;

        // 1: free-running seconds after reset release
        n_sec = 0;
        repeat (35) tick();
        chk("t1_sec_count", 32'(n_sec), 32'd3);

        // 2: glitch rejected, clean press gives one min_en with fixed latency
        press_mode();
        chk("t2_mode_setmin", 32'(bus.mode), 32'd1);
        n_min = 0;
        bus.btn_inc = 1'b1;
        repeat (3) tick();
        bus.btn_inc = 1'b0;
        repeat (10) tick();
        chk("t2_glitch", 32'(n_min), 32'd0);
        t_rise = t + 1;
        t_min  = -1;
        hold_inc(8);
        repeat (12) tick();
        chk("t2_one_min", 32'(n_min), 32'd1);
        chk("t2_latency", 32'(t_min - t_rise), 32'(DEB_CYCLES + 3));

        // 3: mode sequence and sec_clr
        press_mode();
        chk("t3_mode_sethour", 32'(bus.mode), 32'd2);
        n_clr = 0;
        press_mode();
        chk("t3_mode_run", 32'(bus.mode), 32'd0);
        chk("t3_clr_once", 32'(n_clr), 32'd1);
        press_mode();
        chk("t3_mode_01", 32'(bus.mode), 32'd1);
        press_mode();
        chk("t3_mode_10", 32'(bus.mode), 32'd2);
        press_mode();
        chk("t3_mode_00", 32'(bus.mode), 32'd0);

        // 4: auto-repeat in SET_HOUR, pulses at P, P+20, P+25 ... P+45
        press_mode();
        press_mode();
        chk("t4_mode_sethour", 32'(bus.mode), 32'd2);
        n_hour = 0;
        hold_inc(50);
        repeat (12) tick();
        chk("t4_hour_count", 32'(n_hour), 32'd7);

        // 5: coincident mode+inc presses, then inc in RUN
        press_mode();
        press_mode();
        n_min = 0; n_hour = 0;
        bus.btn_mode = 1'b1;
        bus.btn_inc  = 1'b1;
        repeat (6) tick();
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        repeat (10) tick();
        chk("t5_mode_wins", 32'(bus.mode), 32'd2);
        chk("t5_inc_dropped", 32'(n_min + n_hour), 32'd0);
        press_mode();
        chk("t5_mode_run", 32'(bus.mode), 32'd0);
        n_min = 0; n_hour = 0;
        hold_inc(8);
        repeat (10) tick();
        chk("t5_run_ignores_inc", 32'(n_min + n_hour), 32'd0);

        // 6: reset during auto-repeat, button still held across release
        press_mode();
        press_mode();
        bus.btn_inc = 1'b1;
        n_hour = 0;
        repeat (33) tick();
        chk("t6_repeat_running", 32'(n_hour), 32'd3);
        reset = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (3) tick();
        reset = 1'b1;
        n_hour = 0;
        repeat (10) tick();
        bus.btn_inc = 1'b0;
        repeat (10) tick();
        chk("t6_mode_run", 32'(bus.mode), 32'd0);
        chk("t6_no_hour", 32'(n_hour), 32'd0);

        // Random button traffic, including sub-debounce glitches
        for (int k = 0; k < 80; k++) begin
            bus.btn_mode = ($urandom_range(0, 3) == 0);
            bus.btn_inc  = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 30)) tick();
        end
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        repeat (20) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
